// File: rtl/data_ram_lsu.sv
// Byte-addressable data RAM behind a valid/ready request/response port, with RISC-V funct3 sizing and wait states.
// Optional: define DATA_RAM_LSU_MISALIGN_TRAP_EN to flag misaligned accesses instead of aligning them down.
module data_ram_lsu #(
   parameter int XLEN        = 32,
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_write,
   input  logic [2:0]      req_funct3,
   input  logic [XLEN-1:0] req_address,
   input  logic [XLEN-1:0] req_write_data,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [XLEN-1:0] resp_data,
   output logic            resp_error
);

   // state  | meaning
   // S_IDLE | ready for a request; LATENCY==0 commits on the accept edge
   // S_WAIT | counting wait states; commit edge follows cnt==1
   // S_RESP | response held until resp_ready

   localparam int NB = XLEN / 8;
   localparam int LB = $clog2(NB);
   localparam int IW = $clog2(DEPTH_WORDS);
   localparam logic [XLEN-1:0] BYTE_LIMIT = XLEN'(DEPTH_WORDS * NB);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              req_ready_q, req_ready_d;
   logic              resp_valid_q, resp_valid_d;
   logic [XLEN-1:0]   resp_data_q, resp_data_d;
   logic              resp_error_q, resp_error_d;
   logic              wr_q, wr_d;
   logic [2:0]        f3_q, f3_d;
   logic [XLEN-1:0]   addr_q, addr_d;
   logic [XLEN-1:0]   wdata_q, wdata_d;

   logic [XLEN-1:0]   mem_q [DEPTH_WORDS];

   logic              idle, accept, commit, mem_we;
   logic              op_write;
   logic [2:0]        op_f3;
   logic [XLEN-1:0]   op_addr, op_wdata;
   logic [1:0]        sz;
   logic              f3_ok, range_err, align_err, err;
   logic [LB-1:0]     align_m, lane;
   logic [IW-1:0]     idx;
   logic [NB-1:0]     size_be, be;
   logic [XLEN-1:0]   wdata_sh, rd_sh, data_mask, load_val;
   logic              sgn;

   assign idle   = (state_q == S_IDLE);
   assign accept = idle && req_valid && req_ready_q;

   // In IDLE the live request is decoded so LATENCY==0 can commit on the accept edge.
   always_comb begin
      op_write = wr_q;
      op_f3    = f3_q;
      op_addr  = addr_q;
      op_wdata = wdata_q;
      if (idle) begin
         op_write = req_write;
         op_f3    = req_funct3;
         op_addr  = req_address;
         op_wdata = req_write_data;
      end
   end

   always_comb begin
      sz    = op_f3[1:0];
      f3_ok = 1'b0;
      case (op_f3)
         3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
         3'b100, 3'b101:         f3_ok = !op_write;
         3'b011:                 f3_ok = (XLEN == 64);
         3'b110:                 f3_ok = (XLEN == 64) && !op_write;
         default:                f3_ok = 1'b0;
      endcase

      align_m = LB'((32'd1 << sz) - 32'd1);
`ifdef DATA_RAM_LSU_MISALIGN_TRAP_EN
      lane      = op_addr[LB-1:0];
      align_err = |(op_addr[LB-1:0] & align_m);
`else
      lane      = op_addr[LB-1:0] & ~align_m;
      align_err = 1'b0;
`endif
      range_err = (op_addr >= BYTE_LIMIT);
      err       = !f3_ok || range_err || align_err;
      idx       = op_addr[LB +: IW];

      size_be  = NB'((32'd1 << (32'd1 << sz)) - 32'd1);
      be       = size_be << lane;
      wdata_sh = op_wdata << {lane, 3'b000};

      rd_sh     = mem_q[idx] >> {lane, 3'b000};
      data_mask = ~({XLEN{1'b1}} << (32'd8 << sz));
      case (sz)
         2'd0:    sgn = rd_sh[7];
         2'd1:    sgn = rd_sh[15];
         2'd2:    sgn = rd_sh[31];
         default: sgn = rd_sh[XLEN-1];
      endcase
      load_val = (rd_sh & data_mask) | ((sgn && !op_f3[2]) ? ~data_mask : '0);
   end

   assign commit = (accept && (LATENCY == 0)) || ((state_q == S_WAIT) && (cnt_q == 4'd1));
   assign mem_we = commit && op_write && !err && !reset;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      req_ready_d  = req_ready_q;
      resp_valid_d = resp_valid_q;
      resp_data_d  = resp_data_q;
      resp_error_d = resp_error_q;
      wr_d         = wr_q;
      f3_d         = f3_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               wr_d        = req_write;
               f3_d        = req_funct3;
               addr_d      = req_address;
               wdata_d     = req_write_data;
               req_ready_d = 1'b0;
               state_d     = S_WAIT;
               cnt_d       = 4'(LATENCY);
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
         end
         S_RESP: begin
            if (resp_ready) begin
               state_d      = S_IDLE;
               req_ready_d  = 1'b1;
               resp_valid_d = 1'b0;
               resp_data_d  = '0;
               resp_error_d = 1'b0;
            end
         end
         default: begin
            state_d     = S_IDLE;
            req_ready_d = 1'b1;
         end
      endcase
      if (commit) begin
         state_d      = S_RESP;
         cnt_d        = 4'd0;
         resp_valid_d = 1'b1;
         resp_error_d = err;
         resp_data_d  = (err || op_write) ? '0 : load_val;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= 4'd0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
         resp_error_q <= 1'b0;
         wr_q         <= 1'b0;
         f3_q         <= 3'b000;
         addr_q       <= '0;
         wdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         resp_error_q <= resp_error_d;
         wr_q         <= wr_d;
         f3_q         <= f3_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
      end
   end

   // Storage array is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < NB; i++) begin
            if (be[i]) mem_q[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
         end
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_data  = resp_data_q;
   assign resp_error = resp_error_q;

endmodule
